// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and constants for the cache fill arbiter slice: block geometry,
// memory latency, arbiter states and the fill owner encoding.
package cache_fill_arbiter_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_W        = $clog2(WORDS_PER_BLOCK);
  localparam int BYTE_OFF_W      = OFFSET_W + 1;
  localparam int MEM_LATENCY     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_I = 2'd2,
    FILL_D = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  // Clears the byte offset within a block so word reads never carry out of it.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:BYTE_OFF_W], {BYTE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_word_counter.sv
// Word counter for one block fill. Counts 0..WORDS_PER_BLOCK-1, saturates at
// the last word and raises 'full' once the last word has been counted, so the
// owner knows the final step is behind it rather than still pending.
module fill_word_counter
  import cache_fill_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                inc,
  output logic [OFFSET_W-1:0] count,
  output logic                last,
  output logic                full
);

  assign last = (count == OFFSET_W'(WORDS_PER_BLOCK - 1));

  // Count register: cleared by reset or clear, saturating increment with full flag.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
      full  <= 1'b0;
    end else if (inc) begin
      if (last) begin
        full <= 1'b1;
      end else begin
        count <= count + OFFSET_W'(1);
      end
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares the single pipelined main memory between the I-cache and D-cache
// miss paths. Stores go out in one cycle straight from IDLE; block fills
// issue one word read per cycle and steer the returning words into the
// cache that owns the fill.
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_miss_req,
  input  logic [ADDR_W-1:0]   i_miss_addr,
  input  logic                d_miss_req,
  input  logic [ADDR_W-1:0]   d_miss_addr,
  input  logic                d_wr_req,
  input  logic [ADDR_W-1:0]   d_wr_addr,
  input  logic [DATA_W-1:0]   d_wr_data,
  input  logic [DATA_W-1:0]   mem_data_out,
  input  logic                mem_data_valid,
  output logic                mem_enable,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data_in,
  output logic [DATA_W-1:0]   fill_data,
  output logic [OFFSET_W-1:0] fill_word_idx,
  output logic                i_fill_we,
  output logic                d_fill_we,
  output logic                i_fill_done,
  output logic                d_fill_done,
  output logic                d_wr_ack,
  output logic                busy
);

  arb_state_t          state;
  arb_state_t          next_state;
  owner_t              owner;
  owner_t              latch_owner;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-1:0]   latch_addr;
  logic                latch_block;

  logic                cnt_clear;
  logic                issue_inc;
  logic                ret_inc;
  logic [OFFSET_W-1:0] issue_count;
  logic                issue_last_unused;
  logic                issue_full;
  logic [OFFSET_W-1:0] ret_count;
  logic                ret_last;
  logic                ret_full;

  fill_word_counter u_issue_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .inc   (issue_inc),
    .count (issue_count),
    .last  (issue_last_unused),
    .full  (issue_full)
  );

  fill_word_counter u_return_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .inc   (ret_inc),
    .count (ret_count),
    .last  (ret_last),
    .full  (ret_full)
  );

  assign fill_data = mem_data_out;
  assign busy      = rst_n && (state != IDLE);

  // State, owner and block base registers; base/owner only change on a fill grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWNER_I;
      base  <= '0;
    end else begin
      state <= next_state;
      if (latch_block) begin
        owner <= latch_owner;
        base  <= block_base(latch_addr);
      end
    end
  end

  // Arbitration, read issue and fill return steering; everything held at 0 in reset.
  always_comb begin
    next_state    = state;
    latch_block   = 1'b0;
    latch_owner   = owner;
    latch_addr    = base;
    cnt_clear     = 1'b0;
    issue_inc     = 1'b0;
    ret_inc       = 1'b0;
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_data_in   = '0;
    fill_word_idx = '0;
    i_fill_we     = 1'b0;
    d_fill_we     = 1'b0;
    i_fill_done   = 1'b0;
    d_fill_done   = 1'b0;
    d_wr_ack      = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          cnt_clear = 1'b1;
          if (d_wr_req) begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = d_wr_addr;
            mem_data_in = d_wr_data;
            d_wr_ack    = 1'b1;
            next_state  = WRITE;
          end else if (d_miss_req) begin
            latch_block = 1'b1;
            latch_owner = OWNER_D;
            latch_addr  = d_miss_addr;
            next_state  = FILL_D;
          end else if (i_miss_req) begin
            latch_block = 1'b1;
            latch_owner = OWNER_I;
            latch_addr  = i_miss_addr;
            next_state  = FILL_I;
          end
        end
        WRITE: begin
          next_state = IDLE;
        end
        FILL_I, FILL_D: begin
          if (!issue_full) begin
            mem_enable = 1'b1;
            mem_addr   = base + {{(ADDR_W - BYTE_OFF_W){1'b0}}, issue_count, 1'b0};
            issue_inc  = 1'b1;
          end
          if (mem_data_valid && !ret_full) begin
            ret_inc       = 1'b1;
            fill_word_idx = ret_count;
            i_fill_we     = (owner == OWNER_I);
            d_fill_we     = (owner == OWNER_D);
            if (ret_last) begin
              i_fill_done = (owner == OWNER_I);
              d_fill_done = (owner == OWNER_D);
              next_state  = IDLE;
            end
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Self-checking bench for cache_fill_arbiter: a pipelined memory model feeds
// the DUT, expected memory accesses / fill words / done pulses are queued when
// requests are driven and popped as the DUT produces them.
module tb_cache_fill_arbiter;
  import cache_fill_arbiter_pkg::*;

  localparam int FILL_LEN = WORDS_PER_BLOCK + MEM_LATENCY;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } acc_t;

  typedef struct {
    logic                owner;
    logic [OFFSET_W-1:0] idx;
    logic [DATA_W-1:0]   data;
  } fill_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_miss_req = 1'b0;
  logic [ADDR_W-1:0]   i_miss_addr = '0;
  logic                d_miss_req = 1'b0;
  logic [ADDR_W-1:0]   d_miss_addr = '0;
  logic                d_wr_req = 1'b0;
  logic [ADDR_W-1:0]   d_wr_addr = '0;
  logic [DATA_W-1:0]   d_wr_data = '0;
  logic [DATA_W-1:0]   mem_data_out;
  logic                mem_data_valid;
  logic                mem_enable;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_data_in;
  logic [DATA_W-1:0]   fill_data;
  logic [OFFSET_W-1:0] fill_word_idx;
  logic                i_fill_we;
  logic                d_fill_we;
  logic                i_fill_done;
  logic                d_fill_done;
  logic                d_wr_ack;
  logic                busy;

  acc_t  acc_q[$];
  fill_t fill_q[$];
  logic  done_q[$];

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int first_issue = 0;
  logic in_fill = 1'b0;

  logic [MEM_LATENCY-1:0]             valid_pipe = '0;
  logic [MEM_LATENCY-1:0][DATA_W-1:0] data_pipe = '0;

  cache_fill_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_miss_req     (i_miss_req),
    .i_miss_addr    (i_miss_addr),
    .d_miss_req     (d_miss_req),
    .d_miss_addr    (d_miss_addr),
    .d_wr_req       (d_wr_req),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .fill_data      (fill_data),
    .fill_word_idx  (fill_word_idx),
    .i_fill_we      (i_fill_we),
    .d_fill_we      (d_fill_we),
    .i_fill_done    (i_fill_done),
    .d_fill_done    (d_fill_done),
    .d_wr_ack       (d_wr_ack),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] memData(input logic [ADDR_W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Pipelined memory: read data appears MEM_LATENCY cycles after the read is issued.
  always @(posedge clk) begin
    valid_pipe <= {valid_pipe[MEM_LATENCY-2:0], mem_enable && !mem_wr};
    data_pipe  <= {data_pipe[MEM_LATENCY-2:0], memData(mem_addr)};
  end
  assign mem_data_valid = valid_pipe[MEM_LATENCY-1];
  assign mem_data_out   = data_pipe[MEM_LATENCY-1];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    chk_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
  endtask

  task automatic pushFill(input logic owner, input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] a;
    base = addr & 16'hFFF0;
    for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
      a = base + ADDR_W'(2 * k);
      acc_q.push_back('{wr: 1'b0, addr: a, data: '0});
      fill_q.push_back('{owner: owner, idx: OFFSET_W'(k), data: memData(a)});
    end
    done_q.push_back(owner);
  endtask

  task automatic pushWrite(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    acc_q.push_back('{wr: 1'b1, addr: addr, data: data});
  endtask

  // kind: 0 = I-cache miss, 1 = D-cache miss, 2 = store
  task automatic applyStimulus(input int kind, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    case (kind)
      0: begin i_miss_req = 1'b1; i_miss_addr = addr; end
      1: begin d_miss_req = 1'b1; d_miss_addr = addr; end
      default: begin d_wr_req = 1'b1; d_wr_addr = addr; d_wr_data = data; end
    endcase
  endtask

  // One cycle of requester behaviour: drop a request once its done/ack was seen.
  task automatic stepCycle();
    logic id, dd, wa;
    @(negedge clk);
    id = i_fill_done;
    dd = d_fill_done;
    wa = d_wr_ack;
    @(posedge clk);
    #1;
    if (id) i_miss_req = 1'b0;
    if (dd) d_miss_req = 1'b0;
    if (wa) d_wr_req = 1'b0;
  endtask

  task automatic runUntilIdle(input string tag, input int budget);
    int n;
    logic drained;
    n = 0;
    drained = 1'b0;
    while (!drained && n < budget) begin
      stepCycle();
      n++;
      drained = (acc_q.size() == 0) && (fill_q.size() == 0) && (done_q.size() == 0) &&
                !i_miss_req && !d_miss_req && !d_wr_req && !busy;
    end
    checkOutput(tag, {31'd0, drained}, 32'd1);
  endtask

  // Scoreboard monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    acc_t  a;
    fill_t f;
    logic  o;
    cyc++;
    if (!rst_n) in_fill = 1'b0;
    if (mem_enable) begin
      if (acc_q.size() == 0) begin
        checkOutput("mem_unexpected", {15'd0, mem_addr, mem_wr}, 32'd0);
      end else begin
        a = acc_q.pop_front();
        checkOutput("mem_wr", {31'd0, mem_wr}, {31'd0, a.wr});
        checkOutput("mem_addr", {16'd0, mem_addr}, {16'd0, a.addr});
        if (a.wr) begin
          checkOutput("mem_data_in", {16'd0, mem_data_in}, {16'd0, a.data});
          checkOutput("wr_ack", {31'd0, d_wr_ack}, 32'd1);
        end else if (!in_fill) begin
          in_fill = 1'b1;
          first_issue = cyc;
        end
      end
    end else if (d_wr_ack) begin
      checkOutput("ack_without_write", {31'd0, d_wr_ack}, 32'd0);
    end
    if (i_fill_we || d_fill_we) begin
      checkOutput("we_both", {31'd0, i_fill_we && d_fill_we}, 32'd0);
      if (fill_q.size() == 0) begin
        checkOutput("fill_unexpected", {30'd0, i_fill_we, d_fill_we}, 32'd0);
      end else begin
        f = fill_q.pop_front();
        checkOutput("fill_owner", {31'd0, d_fill_we}, {31'd0, f.owner});
        checkOutput("fill_idx", {29'd0, fill_word_idx}, {29'd0, f.idx});
        checkOutput("fill_data", {16'd0, fill_data}, {16'd0, f.data});
      end
    end
    if (i_fill_done || d_fill_done) begin
      if (done_q.size() == 0) begin
        checkOutput("done_unexpected", {30'd0, i_fill_done, d_fill_done}, 32'd0);
      end else begin
        o = done_q.pop_front();
        checkOutput("done_owner", {30'd0, i_fill_done, d_fill_done}, o ? 32'd1 : 32'd2);
        checkOutput("done_last_word",
                    {31'd0, (i_fill_we || d_fill_we) && fill_word_idx == OFFSET_W'(WORDS_PER_BLOCK - 1)},
                    32'd1);
        checkOutput("fill_len", 32'(cyc - first_issue + 1), 32'(FILL_LEN));
      end
      in_fill = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset: a pending store must not leak through while rst_n is low.
    d_wr_req = 1'b1;
    d_wr_addr = 16'h0100;
    d_wr_data = 16'h1111;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    checkOutput("rst_wr_ack", {31'd0, d_wr_ack}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_fill_we", {30'd0, i_fill_we, d_fill_we}, 32'd0);
    checkOutput("rst_done", {30'd0, i_fill_done, d_fill_done}, 32'd0);
    @(posedge clk);
    #1;
    d_wr_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) stepCycle();

    $display("[TB] I-cache miss alone at 0x1236");
    pushFill(1'b0, 16'h1236);
    applyStimulus(0, 16'h1236, '0);
    stepCycle();
    checkOutput("busy_fill", {31'd0, busy}, 32'd1);
    runUntilIdle("drain_i_alone", 40);

    $display("[TB] I and D misses in the same cycle");
    pushFill(1'b1, 16'h4000);
    pushFill(1'b0, 16'h0A48);
    applyStimulus(0, 16'h0A48, '0);
    applyStimulus(1, 16'h4000, '0);
    runUntilIdle("drain_i_and_d", 80);

    $display("[TB] store arriving during an I fill");
    pushFill(1'b0, 16'h3000);
    pushWrite(16'h2002, 16'hBEEF);
    applyStimulus(0, 16'h3000, '0);
    repeat (3) stepCycle();
    applyStimulus(2, 16'h2002, 16'hBEEF);
    runUntilIdle("drain_store_in_fill", 60);

    $display("[TB] store and D miss in the same cycle");
    pushWrite(16'h6006, 16'h1234);
    pushFill(1'b1, 16'h7F1C);
    applyStimulus(1, 16'h7F1C, '0);
    applyStimulus(2, 16'h6006, 16'h1234);
    runUntilIdle("drain_store_then_d", 60);

    $display("[TB] reset in the middle of a fill");
    pushFill(1'b0, 16'h5550);
    applyStimulus(0, 16'h5550, '0);
    repeat (5) stepCycle();
    rst_n = 1'b0;
    i_miss_req = 1'b0;
    acc_q.delete();
    fill_q.delete();
    done_q.delete();
    repeat (2) stepCycle();
    rst_n = 1'b1;
    repeat (6) stepCycle();
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
    pushFill(1'b0, 16'h5552);
    applyStimulus(0, 16'h5552, '0);
    runUntilIdle("drain_after_reset", 40);

    $display("[TB] miss at top of address space 0xFFF8");
    pushFill(1'b1, 16'hFFF8);
    applyStimulus(1, 16'hFFF8, '0);
    runUntilIdle("drain_top_addr", 40);

    repeat (2) stepCycle();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
